// File: rtl/fifo_mbox.sv
// Single-clock mailbox FIFO with optional strobe edge-synchronisation,
// sticky overflow/underflow flags and almost-full/almost-empty thresholds.
module fifo_mbox #(
  parameter int DW        = 8,
  parameter int AW        = 11,
  parameter int AFULL_TH  = (1 << AW) - 16,
  parameter int AEMPTY_TH = 0,
  parameter int SYNC      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_ce,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_ce,
  output logic [DW-1:0] rd_data,
  input  logic          flush,
  input  logic          clr_err,
  output logic          empty,
  output logic          full,
  output logic          afull,
  output logic          aempty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] AFULL_L  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_L = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [2:0]    wr_sh_r;
  logic [1:0]    rd_sh_r;
  logic          rd_arm_r;
  logic          ovf_r;
  logic          udf_r;
  logic [DW-1:0] rd_data_r;

  logic wev_s;
  logic rev_s;
  logic rd_rise_s;
  logic udf_set_s;
  logic ovf_set_s;
  logic wr_ok_s;

  assign level   = wr_ptr_r - rd_ptr_r;
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign afull   = (level >= AFULL_L);
  assign aempty  = (level <= AEMPTY_L);
  assign ovf     = ovf_r;
  assign udf     = udf_r;
  assign rd_data = rd_data_r;

  // Event decode: edge-detected bus strobes or direct one-cycle pulses.
  always_comb begin
    wev_s     = 1'b0;
    rev_s     = 1'b0;
    rd_rise_s = 1'b0;
    udf_set_s = 1'b0;
    if (SYNC != 0) begin
      wev_s     = (wr_sh_r == 3'b011);
      rd_rise_s = (rd_sh_r == 2'b01);
      rev_s     = (rd_sh_r == 2'b10) && rd_arm_r;
      udf_set_s = rd_rise_s && empty;
    end else begin
      wev_s     = wr_ce;
      rev_s     = rd_ce && !empty;
      udf_set_s = rd_ce && empty;
    end
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    wr_ok_s   = wev_s && (!full || rev_s) && !flush;
    ovf_set_s = wev_s && full && !rev_s && !flush;
  end

  // Strobe sampling shift registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sh_r <= 3'b000;
      rd_sh_r <= 2'b00;
    end else begin
      wr_sh_r <= {wr_sh_r[1:0], wr_ce};
      rd_sh_r <= {rd_sh_r[0], rd_ce};
    end
  end

  // Pointers and read arming; flush overrides both events.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      rd_arm_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      rd_arm_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rev_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        rd_arm_r <= 1'b0;
      end else if (rd_rise_s) begin
        rd_arm_r <= !empty;
      end
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(negedge clk) begin
    if (wr_ok_s) begin
      mem[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Registered head word; holds the last value read once the FIFO drains.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= '0;
    end else if (!empty) begin
      rd_data_r <= mem[rd_ptr_r[AW-1:0]];
    end
  end

  // Sticky error flags; a new error wins over clr_err.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_err) begin
        ovf_r <= 1'b0;
      end
      if (udf_set_s) begin
        udf_r <= 1'b1;
      end else if (clr_err) begin
        udf_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_mbox.sv
// Directed bench: instance a uses edge-synchronised strobes, instance b one-cycle pulses.
module tb_fifo_mbox;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       clr_err;

  logic       wr_ce_a, rd_ce_a;
  logic [7:0] wr_data_a, rd_data_a;
  logic       empty_a, full_a, afull_a, aempty_a, ovf_a, udf_a;
  logic [4:0] level_a;

  logic       wr_ce_b, rd_ce_b;
  logic [7:0] wr_data_b, rd_data_b;
  logic       empty_b, full_b, afull_b, aempty_b, ovf_b, udf_b;
  logic [4:0] level_b;

  int errors;
  int checks;

  fifo_mbox #(.DW(8), .AW(4), .AFULL_TH(12), .AEMPTY_TH(2), .SYNC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_ce(wr_ce_a), .wr_data(wr_data_a),
    .rd_ce(rd_ce_a), .rd_data(rd_data_a), .flush(flush), .clr_err(clr_err),
    .empty(empty_a), .full(full_a), .afull(afull_a), .aempty(aempty_a),
    .level(level_a), .ovf(ovf_a), .udf(udf_a)
  );

  fifo_mbox #(.DW(8), .AW(4), .AFULL_TH(14), .AEMPTY_TH(0), .SYNC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_ce(wr_ce_b), .wr_data(wr_data_b),
    .rd_ce(rd_ce_b), .rd_data(rd_data_b), .flush(flush), .clr_err(clr_err),
    .empty(empty_b), .full(full_b), .afull(afull_b), .aempty(aempty_b),
    .level(level_b), .ovf(ovf_b), .udf(udf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Four-sample write strobe followed by settling time.
  task automatic a_write(input logic [7:0] d);
    wr_data_a = d;
    wr_ce_a = 1'b1;
    repeat (4) @(posedge clk);
    wr_ce_a = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Read strobe; the head word is captured while the strobe is held.
  task automatic a_read(output logic [7:0] d);
    rd_ce_a = 1'b1;
    repeat (3) @(posedge clk);
    d = rd_data_a;
    @(posedge clk);
    rd_ce_a = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (level_a !== 5'd0)  begin errors++; $display("FAIL reset_level: got %0d want 0", level_a); end
    checks++; if ({empty_a, full_a, afull_a, aempty_a} !== 4'b1001) begin errors++; $display("FAIL reset_flags: got %b want 1001", {empty_a, full_a, afull_a, aempty_a}); end
    checks++; if ({ovf_a, udf_a, ovf_b, udf_b} !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b want 0000", {ovf_a, udf_a, ovf_b, udf_b}); end
    checks++; if (rd_data_a !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data_a); end
    checks++; if ({empty_b, afull_b, level_b} !== {1'b1, 1'b0, 5'd0}) begin errors++; $display("FAIL reset_b: got %b/%b/%0d want 1/0/0", empty_b, afull_b, level_b); end
    @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] d;
    a_write(8'hA5);
    a_write(8'h3C);
    checks++; if (level_a !== 5'd2) begin errors++; $display("FAIL basic_level: got %0d want 2", level_a); end
    checks++; if (empty_a !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b want 0", empty_a); end
    checks++; if (aempty_a !== 1'b1) begin errors++; $display("FAIL basic_aempty_at2: got %b want 1", aempty_a); end
    a_read(d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL basic_rd0: got %h want a5", d); end
    a_read(d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL basic_rd1: got %h want 3c", d); end
    checks++; if ({empty_a, udf_a} !== 2'b10) begin errors++; $display("FAIL basic_end: got empty/udf %b want 10", {empty_a, udf_a}); end
  endtask

  task automatic test_full;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      a_write(8'(i));
      if (i == 2) begin
        checks++; if (aempty_a !== 1'b0) begin errors++; $display("FAIL thr_aempty_at3: got %b want 0", aempty_a); end
      end
      if (i == 10) begin
        checks++; if (afull_a !== 1'b0) begin errors++; $display("FAIL thr_afull_at11: got %b want 0", afull_a); end
      end
      if (i == 11) begin
        checks++; if (afull_a !== 1'b1) begin errors++; $display("FAIL thr_afull_at12: got %b want 1", afull_a); end
      end
    end
    checks++; if ({full_a, level_a} !== {1'b1, 5'd16}) begin errors++; $display("FAIL full_state: got %b/%0d want 1/16", full_a, level_a); end
    a_write(8'hEE);
    checks++; if ({ovf_a, level_a} !== {1'b1, 5'd16}) begin errors++; $display("FAIL full_ovf: got %b/%0d want 1/16", ovf_a, level_a); end
    clr_err = 1'b1;
    @(posedge clk);
    clr_err = 1'b0;
    @(posedge clk);
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL full_clr_err: got %b want 0", ovf_a); end
    for (int i = 0; i < 16; i++) begin
      a_read(d);
      checks++; if (d !== 8'(i)) begin errors++; $display("FAIL full_rd%0d: got %h want %h", i, d, 8'(i)); end
    end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", empty_a); end
  endtask

  task automatic test_underflow;
    logic [7:0] d;
    a_read(d);
    checks++; if ({udf_a, empty_a, level_a} !== {1'b1, 1'b1, 5'd0}) begin errors++; $display("FAIL udf_set: got %b/%b/%0d want 1/1/0", udf_a, empty_a, level_a); end
    wr_data_a = 8'h11;
    wr_ce_a = 1'b1;
    repeat (3) @(posedge clk);
    checks++; if ({level_a, rd_data_a} !== {5'd1, 8'h0F}) begin errors++; $display("FAIL udf_wr_edge2: got %0d/%h want 1/0f", level_a, rd_data_a); end
    @(posedge clk);
    checks++; if (rd_data_a !== 8'h11) begin errors++; $display("FAIL udf_wr_edge3: got %h want 11", rd_data_a); end
    wr_ce_a = 1'b0;
    repeat (3) @(posedge clk);
    a_read(d);
    checks++; if ({d, empty_a} !== {8'h11, 1'b1}) begin errors++; $display("FAIL udf_rd: got %h/%b want 11/1", d, empty_a); end
  endtask

  task automatic test_sync0;
    wr_ce_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data_b = 8'(i);
      @(posedge clk);
    end
    wr_ce_b = 1'b0;
    @(posedge clk);
    checks++; if ({full_b, level_b} !== {1'b1, 5'd16}) begin errors++; $display("FAIL s0_fill: got %b/%0d want 1/16", full_b, level_b); end
    wr_ce_b = 1'b1;
    rd_ce_b = 1'b1;
    wr_data_b = 8'h77;
    @(posedge clk);
    wr_ce_b = 1'b0;
    rd_ce_b = 1'b0;
    @(posedge clk);
    checks++; if ({full_b, ovf_b, level_b} !== {1'b1, 1'b0, 5'd16}) begin errors++; $display("FAIL s0_wr_rd_full: got %b/%b/%0d want 1/0/16", full_b, ovf_b, level_b); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i < 15) ? 8'(i + 1) : 8'h77;
      checks++; if (rd_data_b !== exp) begin errors++; $display("FAIL s0_rd%0d: got %h want %h", i, rd_data_b, exp); end
      rd_ce_b = 1'b1;
      @(posedge clk);
      rd_ce_b = 1'b0;
      repeat (2) @(posedge clk);
    end
    checks++; if ({empty_b, udf_b} !== 2'b10) begin errors++; $display("FAIL s0_drained: got %b want 10", {empty_b, udf_b}); end
    wr_ce_b = 1'b1;
    rd_ce_b = 1'b1;
    wr_data_b = 8'h5A;
    @(posedge clk);
    wr_ce_b = 1'b0;
    rd_ce_b = 1'b0;
    repeat (2) @(posedge clk);
    checks++; if ({level_b, udf_b, rd_data_b} !== {5'd1, 1'b1, 8'h5A}) begin errors++; $display("FAIL s0_wr_rd_empty: got %0d/%b/%h want 1/1/5a", level_b, udf_b, rd_data_b); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 9; i++) a_write(8'(8'h20 + i));
    checks++; if (level_a !== 5'd9) begin errors++; $display("FAIL flush_pre: got %0d want 9", level_a); end
    wr_data_a = 8'hEE;
    wr_ce_a = 1'b1;
    repeat (2) @(posedge clk);
    flush = 1'b1;
    @(posedge clk);
    flush = 1'b0;
    @(posedge clk);
    wr_ce_a = 1'b0;
    repeat (3) @(posedge clk);
    checks++; if ({level_a, empty_a} !== {5'd0, 1'b1}) begin errors++; $display("FAIL flush_state: got %0d/%b want 0/1", level_a, empty_a); end
    checks++; if ({ovf_a, udf_a} !== 2'b01) begin errors++; $display("FAIL flush_err_kept: got %b want 01", {ovf_a, udf_a}); end
    clr_err = 1'b1;
    @(posedge clk);
    clr_err = 1'b0;
    @(posedge clk);
    checks++; if (udf_a !== 1'b0) begin errors++; $display("FAIL clr_udf: got %b want 0", udf_a); end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      a_write(8'(8'h40 + i));
      checks++; if (level_a !== 5'd1) begin errors++; $display("FAIL wrap_level%0d: got %0d want 1", i, level_a); end
      a_read(d);
      checks++; if (d !== 8'(8'h40 + i)) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", i, d, 8'(8'h40 + i)); end
    end
    wr_data_a = 8'h99;
    wr_ce_a = 1'b1;
    @(posedge clk);
    wr_ce_a = 1'b0;
    repeat (5) @(posedge clk);
    checks++; if ({level_a, empty_a} !== {5'd0, 1'b1}) begin errors++; $display("FAIL glitch: got %0d/%b want 0/1", level_a, empty_a); end
  endtask

  task automatic test_reset_mid;
    a_write(8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({level_a, empty_a, rd_data_a} !== {5'd0, 1'b1, 8'h00}) begin errors++; $display("FAIL reset_mid: got %0d/%b/%h want 0/1/00", level_a, empty_a, rd_data_a); end
    @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    flush = 1'b0;
    clr_err = 1'b0;
    wr_ce_a = 1'b0; rd_ce_a = 1'b0; wr_data_a = 8'h00;
    wr_ce_b = 1'b0; rd_ce_b = 1'b0; wr_data_b = 8'h00;
    test_reset;
    test_basic;
    test_full;
    test_underflow;
    test_sync0;
    test_flush;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_mbox.md
# fifo_mbox

Parametrised single-clock mailbox FIFO for the MCU↔CPU data channels: successor to the fixed 8-bit, 2048-entry channel FIFO. It adds the following over that FIFO:
- configurable width and depth;
- a true full flag, with overflow/underflow detection;
- almost-full/almost-empty thresholds;
- flush;
- a selectable strobe mode (raw async bus strobes edge-synchronised internally, or clean one-cycle pulses).

One instance per direction; status outputs feed the base I/O status registers.

## Interface
Parameters:
- DW, 8: data width in bits.
- AW, 11: address width; depth = 2^AW words.
- AFULL_TH, 2^AW-16: afull asserts when level >= AFULL_TH.
- AEMPTY_TH, 0: aempty asserts when level <= AEMPTY_TH.
- SYNC, 1: 1 = wr_ce/rd_ce are raw bus levels (edge-synchronised here); 0 = one-cycle synchronous pulses.

Ports:
- clk  in  1  system clock. All registers update on the falling edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_ce  in  1  write strobe; wr_data must be stable while it is high.
- wr_data  in  DW  write word.
- rd_ce  in  1  read strobe; the pop happens on its trailing edge.
- rd_data  out  DW  head word, registered.
- flush  in  1  synchronous clear of the contents.
- clr_err  in  1  synchronous clear of ovf/udf.
- empty  out  1  level == 0.
- full  out  1  level == 2^AW.
- afull  out  1  almost full.
- aempty  out  1  almost empty.
- level  out  AW+1  word count.
- ovf  out  1  sticky: a write was dropped because the FIFO was full.
- udf  out  1  sticky: a read was attempted while empty.

## Operation
Pointers:
- wr_ptr/rd_ptr are AW+1 bits and wrap modulo 2^(AW+1).
- level = wr_ptr - rd_ptr (AW+1-bit subtract).
- Memory address = ptr[AW-1:0].
- full ⇔ MSBs differ and the lower bits are equal.

Strobe sampling, SYNC=1 (shift registers wst[2:0], rst_[2:0] on the raw strobes):
- Write event wev = (wst == 3'b011): high for exactly one cycle per wr_ce assertion, after two consecutive high samples.
- rd_ce assertion: on the first high sample (rst_[0] rising), latch rd_arm = !empty. If empty, set udf.
- Pop event rev = (rst_[1:0] == 2'b10) & rd_arm; rd_arm clears in the same cycle.

Strobe sampling, SYNC=0:
- wev = wr_ce.
- On rd_ce, rev = rd_ce & !empty; udf is set if empty.
- Pulses longer than one cycle produce one event per cycle.

Write:
- On wev: if !full, or rev fires in the same cycle, then mem[wr_ptr] <= wr_data and wr_ptr++.
- Otherwise the word is dropped and ovf <= 1.

Read:
- On rev: rd_ptr++.
- rd_data <= mem[rd_ptr] every cycle (first-word-fall-through after 1 cycle).
- When empty, rd_data holds the last value read from memory.

Simultaneous events:
- wev+rev when empty: cannot occur in SYNC=1, because rd_arm requires prior non-empty. In SYNC=0 no pop happens, the write lands, and udf is set.
- wev+rev when full: both proceed, level stays 2^AW, ovf not set.

Flush:
- rd_ptr <= wr_ptr <= 0; rd_arm <= 0.
- Overrides wev/rev in the same cycle.
- ovf/udf unaffected.

clr_err:
- ovf <= udf <= 0.
- A set condition in the same cycle wins.

Flags:
- empty/full/level/afull/aempty are combinational from the registered pointers.

## Timing
Reset values:
- wr_ptr = rd_ptr = 0, level = 0.
- empty = 1, full = 0, afull = 0 (AFULL_TH>0), aempty = 1.
- ovf = udf = 0, rd_data = 0.
- wst = rst_ = 0, rd_arm = 0.

Write path, SYNC=1 (wr_ce first sampled high at edge k):
- wev high between edges k+1 and k+2.
- wr_ptr updates at k+2, so empty/level change after k+2.
- rd_data reflects a newly written head after k+3.

Read path, SYNC=1:
- Pop at the first edge after rd_ce is sampled low (low sample at edge j: rd_ptr updates at j+1).
- rd_data shows the next word after j+2.
- rd_data is stable for the whole rd_ce assertion.

Latency, SYNC=0:
- Pointer updates at the edge following the pulse.
- rd_data follows one edge later.

Glitches:
- A strobe high for a single sample produces no write event (SYNC=1).

Reset mid-operation:
- rst_n low clears everything asynchronously, including in-flight events.
- Memory contents are undefined and not cleared.

## Test plan
- Reset, then SYNC=1, DW=8, AW=4: write 0xA5, 0x3C with 4-cycle strobes → level=2, empty=0; two reads return 0xA5 then 0x3C; then empty=1, udf=0.
- Fill to 16 words → full=1, level=16; a 17th write (0xEE) → dropped, ovf=1, level=16; clr_err → ovf=0; the read sequence is intact 0..15.
- Read strobe while empty → udf=1, rd_ptr unchanged; then write 0x11 → rd_data=0x11 after 3 edges.
- Full FIFO, SYNC=0, same-cycle wr_ce (0x77) and rd_ce → level stays 16, ovf=0, 0x77 is the last word out.
- AFULL_TH=12, AEMPTY_TH=2: level 2→3 clears aempty; 11→12 sets afull. flush at level 9 concurrent with wev → level=0, empty=1, ovf/udf unchanged.
- Pointer wrap: 40 write/read pairs on AW=4 → data matches, level never exceeds 1; one-sample wr_ce glitch → no write.
